// File: rtl/vecmac_pkg.sv
// Shared types and constants for the dot-product sequencer and its
// accumulator.
package vecmac_pkg;

    localparam int MAC_SUM_W = 18;
    localparam int BEAT_W    = 32;
    localparam int LANES     = 4;

    localparam int DEF_LEN_W = 8;
    localparam int DEF_ACC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vecmac_state_e;

endpackage

// File: rtl/vecmac_dot_ctrl_if.sv
// Command, operand and result channels of the dot-product sequencer.
interface vecmac_dot_ctrl_if
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;

    logic              op_valid;
    logic              op_ready;
    logic [BEAT_W-1:0] op_a;
    logic [BEAT_W-1:0] op_b;

    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_data
    );

endinterface

// File: rtl/vecmac_acc.sv
// Accumulates datapath partial sums and counts returned beats against the
// command length; flags returns that arrive when none are outstanding.
module vecmac_acc
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 active,
    input  logic                 mac_out_valid,
    input  logic [MAC_SUM_W-1:0] mac_out_sum,
    input  logic [LEN_W-1:0]     len,
    output logic [ACC_W-1:0]     acc,
    output logic                 last_ret,
    output logic                 spurious
);

    logic [LEN_W-1:0] ret_cnt;
    logic             take;

    assign take     = mac_out_valid && active && (ret_cnt != len);
    assign last_ret = take && (ret_cnt == len - LEN_W'(1));
    assign spurious = mac_out_valid && !take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            ret_cnt <= '0;
        end else if (clear) begin
            acc     <= '0;
            ret_cnt <= '0;
        end else if (take) begin
            acc     <= acc + ACC_W'(mac_out_sum);
            ret_cnt <= ret_cnt + LEN_W'(1);
        end
    end

endmodule

// File: rtl/vecmac_dot_ctrl.sv
// Sequences operand beats into the 4-lane MAC datapath and returns the
// accumulated dot product; counts returns, so datapath latency is irrelevant.
//   state | meaning
//   IDLE  | waiting for a command
//   ISSUE | forwarding operand beats, absorbing early returns
//   DRAIN | all beats issued, waiting for remaining returns
//   DONE  | result presented until consumed
module vecmac_dot_ctrl
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vecmac_dot_ctrl_if.slave     bus,
    output logic                 mac_in_valid,
    output logic [BEAT_W-1:0]    mac_in_a,
    output logic [BEAT_W-1:0]    mac_in_b,
    input  logic                 mac_out_valid,
    input  logic [MAC_SUM_W-1:0] mac_out_sum,
    output logic                 busy,
    output logic                 err_spurious
);

    if (ACC_W < MAC_SUM_W + LEN_W) begin : g_acc_w_check
        $error("vecmac_dot_ctrl: ACC_W too narrow for worst-case dot product");
    end

    vecmac_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issue_cnt;
    logic [ACC_W-1:0] acc;
    logic             cmd_fire, op_fire, res_fire;
    logic             last_issue, last_ret, acc_spurious, active;

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.op_ready  = (state_q == ST_ISSUE);
    assign bus.res_valid = (state_q == ST_DONE);
    // acc is frozen outside ISSUE/DRAIN, so it doubles as the held result.
    assign bus.res_data  = acc;
    assign busy          = (state_q != ST_IDLE);

    assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
    assign op_fire    = bus.op_valid && bus.op_ready;
    assign res_fire   = bus.res_valid && bus.res_ready;
    assign last_issue = (issue_cnt == len_q - LEN_W'(1));
    assign active     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = (bus.cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_fire && last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_ret) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q        <= '0;
            issue_cnt    <= '0;
            mac_in_valid <= 1'b0;
            mac_in_a     <= '0;
            mac_in_b     <= '0;
            err_spurious <= 1'b0;
        end else begin
            mac_in_valid <= op_fire;
            if (cmd_fire) begin
                len_q     <= bus.cmd_len;
                issue_cnt <= '0;
            end else if (op_fire) begin
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
            if (op_fire) begin
                mac_in_a <= bus.op_a;
                mac_in_b <= bus.op_b;
            end
            if (acc_spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

    vecmac_acc #(
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (cmd_fire),
        .active        (active),
        .mac_out_valid (mac_out_valid),
        .mac_out_sum   (mac_out_sum),
        .len           (len_q),
        .acc           (acc),
        .last_ret      (last_ret),
        .spurious      (acc_spurious)
    );

endmodule

// File: tb/tb_vecmac_dot_ctrl.sv
// Scoreboard bench for vecmac_dot_ctrl with a two-stage behavioural model of
// the MAC datapath.
module tb_vecmac_dot_ctrl;
    import vecmac_pkg::*;

    localparam int LW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vecmac_dot_ctrl_if #(.LEN_W(LW), .ACC_W(AW)) bus();

    logic                 mac_in_valid;
    logic [BEAT_W-1:0]    mac_in_a, mac_in_b;
    logic                 mac_out_valid;
    logic [MAC_SUM_W-1:0] mac_out_sum;
    logic                 busy, err_spurious;

    vecmac_dot_ctrl #(.LEN_W(LW), .ACC_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .mac_in_valid  (mac_in_valid),
        .mac_in_a      (mac_in_a),
        .mac_in_b      (mac_in_b),
        .mac_out_valid (mac_out_valid),
        .mac_out_sum   (mac_out_sum),
        .busy          (busy),
        .err_spurious  (err_spurious)
    );

    // Datapath model: two-cycle latency, shares rst_n; inj_* forces a return.
    logic                 p1_v, p2_v, inj_v;
    logic [MAC_SUM_W-1:0] p1_s, p2_s, inj_s;

    function automatic logic [MAC_SUM_W-1:0] dot4(logic [31:0] a, logic [31:0] b);
        logic [MAC_SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            s = s + MAC_SUM_W'(a[8*i +: 8]) * MAC_SUM_W'(b[8*i +: 8]);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_s <= '0; p2_s <= '0;
        end else begin
            p1_v <= mac_in_valid;
            p1_s <= dot4(mac_in_a, mac_in_b);
            p2_v <= p1_v;
            p2_s <= p1_s;
        end
    end

    assign mac_out_valid = p2_v | inj_v;
    assign mac_out_sum   = inj_v ? inj_s : p2_s;

    int vectors = 0;
    int miscompares = 0;
    logic [AW-1:0] exp_q[$];
    int pulses = 0;
    int streak = 0;
    int max_streak = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pulse statistics and result scoreboard.
    always @(negedge clk) begin
        if (mac_in_valid) begin
            pulses++;
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got %0d expected no result", bus.res_data);
            end else begin
                check("res_data", 64'(bus.res_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int len);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1'b1;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("cmd_timeout", 0, 1);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) tick();
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.op_ready) ok = 1'b1;
            tick();
        end
        bus.op_valid = 1'b0;
        if (!ok) check("op_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check("idle_timeout", 64'(ok), 1);
        tick();
    endtask

    task automatic start_stats();
        pulses     = 0;
        max_streak = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b1;
        inj_v = 1'b0;
        inj_s = '0;
        rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mac_in_valid", 64'(mac_in_valid), 0);
        check("rst_mac_in_a", 64'(mac_in_a), 0);
        check("rst_res_valid", 64'(bus.res_valid), 0);
        check("rst_res_data", 64'(bus.res_data), 0);
        check("rst_err", 64'(err_spurious), 0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 1);
        check("rst_op_ready", 64'(bus.op_ready), 0);
        check("rst_busy", 64'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // len=1, all-ones bytes: 4
        start_stats();
        exp_q.push_back(32'd4);
        send_cmd(1);
        send_beat(32'h01010101, 32'h01010101, 0);
        wait_idle();
        check("t1_pulses", 64'(pulses), 1);

        // len=4, max operands, continuous: 4*260100
        start_stats();
        exp_q.push_back(32'd1040400);
        send_cmd(4);
        for (int i = 0; i < 4; i++) send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        wait_idle();
        check("t2_pulses", 64'(pulses), 4);
        check("t2_streak", 64'(max_streak), 4);

        // len=3 with 2-cycle gaps: 3*24
        start_stats();
        exp_q.push_back(32'd72);
        send_cmd(3);
        for (int i = 0; i < 3; i++) send_beat(32'h02020202, 32'h03030303, 2);
        wait_idle();
        check("t3_pulses", 64'(pulses), 3);
        check("t3_streak", 64'(max_streak), 1);

        // len=2 mixed lanes: 20 + 767
        start_stats();
        exp_q.push_back(32'd787);
        send_cmd(2);
        send_beat(32'h04030201, 32'h01020304, 0);
        send_beat(32'h80FF0010, 32'h02010010, 1);
        wait_idle();
        check("t4_pulses", 64'(pulses), 2);

        // len=0 held in DONE for 10 cycles
        start_stats();
        bus.res_ready = 1'b0;
        exp_q.push_back(32'd0);
        send_cmd(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_res_valid", 64'(bus.res_valid), 1);
            check("t5_res_data", 64'(bus.res_data), 0);
            check("t5_cmd_ready", 64'(bus.cmd_ready), 0);
            check("t5_op_ready", 64'(bus.op_ready), 0);
        end
        tick();
        bus.res_ready = 1'b1;
        wait_idle();
        check("t5_pulses", 64'(pulses), 0);

        // Reset after 2 of 5 beats, then a fresh len=1 command: 1+2+3+4
        send_cmd(5);
        send_beat(32'h11111111, 32'h22222222, 0);
        send_beat(32'h33333333, 32'h44444444, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_busy", 64'(busy), 0);
        check("t6_cmd_ready", 64'(bus.cmd_ready), 1);
        check("t6_res_valid", 64'(bus.res_valid), 0);
        tick();
        exp_q.push_back(32'd10);
        send_cmd(1);
        send_beat(32'h01020304, 32'h01010101, 0);
        wait_idle();

        // Spurious return in IDLE: sticky flag, next result unaffected
        check("t7_err_before", 64'(err_spurious), 0);
        inj_v = 1'b1;
        inj_s = 18'd1000;
        tick();
        inj_v = 1'b0;
        @(negedge clk);
        check("t7_err_set", 64'(err_spurious), 1);
        tick();
        exp_q.push_back(32'd4);
        send_cmd(1);
        send_beat(32'h01010101, 32'h01010101, 0);
        wait_idle();
        check("t7_err_sticky", 64'(err_spurious), 1);

        repeat (5) tick();
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
